rhs_headstage_emulator_array: RTL and testbench

- Parametrised multi-port emulator of Intan RHS2116 headstage SPI slaves.
- Drives deterministic per-port sample data back to the controller's SPI master, so the acquisition path can be tested without hardware.
- Sits at the headstage-facing edge of the controller; all ports share MOSI/CS/SCLK and each port has its own MISO.
- Generalises the fixed 16-port emulator:
  - configurable port and channel count;
  - full 32-bit command decode with two-frame result pipeline;
  - register file with read/write echo;
  - selectable data mode;
  - frame-error detection.

---
 rtl/rhs_headstage_emulator_array_if.sv | 13 +
 rtl/rhs_headstage_emulator_array.sv | 149 ++++++++++++++
 tb/tb_rhs_headstage_emulator_array.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rhs_headstage_emulator_array_if.sv
// Shared SPI bus between the controller's master and the emulated headstages.
// MOSI/CS/SCLK are common to all chips; every chip has its own MISO line.
interface rhs_headstage_emulator_array_if #(
    parameter int NUM_PORTS = 16
);
    logic                 MOSI;
    logic                 CS;
    logic                 SCLK;
    logic [NUM_PORTS-1:0] MISO;

    modport master (output MOSI, output CS, output SCLK, input MISO);
    modport slave  (input MOSI, input CS, input SCLK, output MISO);
endinterface

// File: rtl/rhs_headstage_emulator_array.sv
// Emulates NUM_PORTS Intan RHS2116 SPI slaves sharing one command stream.
// Each chip answers command N during frame N+2.
module rhs_headstage_emulator_array #(
    parameter int          NUM_PORTS    = 16,
    parameter int          NUM_CHANNELS = 16,
    parameter logic [15:0] SEED_BASE    = 16'd2048,
    parameter logic [15:0] SEED_STRIDE  = 16'd16,
    parameter int          REG_DEPTH    = 32,
    parameter logic [15:0] CHIP_ID      = 16'h0020
) (
    input  logic                                 clk,
    input  logic                                 reset,
    rhs_headstage_emulator_array_if.slave        spi,
    input  logic                                 test_mode,
    output logic [15:0]                          frame_count,
    output logic                                 frame_error
);
    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FRAME, DONE} state_t;

    state_t                         state;
    logic [2:0]                     cs_s, sclk_s;
    logic [1:0]                     mosi_s;
    logic                           cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [5:0]                     bit_cnt;
    logic [31:0]                    rx_sr;
    logic [NUM_PORTS-1:0][31:0]     tx_sr, res_q1, res_q2, result;
    logic [NUM_PORTS-1:0][15:0]     sample;
    logic [NUM_PORTS-1:0]           miso;
    logic [REG_DEPTH-1:0][15:0]     regs;
    logic [15:0]                    conv_count, rd_val;
    logic [1:0]                     op;
    logic [5:0]                     ch;
    logic [7:0]                     addr;
    logic [15:0]                    wdata;
    logic                           unused_bits;

    assign op          = rx_sr[31:30];
    assign ch          = rx_sr[21:16];
    assign addr        = rx_sr[23:16];
    assign wdata       = rx_sr[15:0];
    assign unused_bits = ^rx_sr[29:24];
    assign spi.MISO    = miso;

    // Sync stages reset low so a CS already low at reset release never looks like a fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_s   <= '0;
            sclk_s <= '0;
            mosi_s <= '0;
        end else begin
            cs_s   <= {cs_s[1:0], spi.CS};
            sclk_s <= {sclk_s[1:0], spi.SCLK};
            mosi_s <= {mosi_s[0], spi.MOSI};
        end
    end

    assign cs_fall   =  cs_s[2]   & ~cs_s[1];
    assign cs_rise   = ~cs_s[2]   &  cs_s[1];
    assign sclk_rise = ~sclk_s[2] &  sclk_s[1];
    assign sclk_fall =  sclk_s[2] & ~sclk_s[1];

    always_comb begin
        sample = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            sample[p] = test_mode ? (16'h5555 ^ 16'(p))
                                  : SEED_BASE + 16'(p) * SEED_STRIDE + {10'b0, ch} + conv_count;
    end

    always_comb begin
        rd_val = '0;
        if (32'(addr) < REG_DEPTH) rd_val = regs[addr[AW-1:0]];
        else if (addr == 8'd255)   rd_val = CHIP_ID;
    end

    always_comb begin
        result = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            case (op)
                2'b00:   if (32'(ch) < NUM_CHANNELS) result[p] = {10'b0, ch, sample[p]};
                2'b10:   result[p] = {16'hFFFF, wdata};
                2'b11:   result[p] = {16'h0000, rd_val};
                default: result[p] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            miso        <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            res_q1      <= '0;
            res_q2      <= '0;
            regs        <= '0;
            conv_count  <= '0;
            frame_count <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    miso <= '0;
                    if (cs_fall) begin
                        state   <= FRAME;
                        tx_sr   <= res_q2;
                        bit_cnt <= '0;
                        for (int p = 0; p < NUM_PORTS; p++) miso[p] <= res_q2[p][31];
                    end
                end
                FRAME: begin
                    // CS edge takes priority over any coincident SCLK edge.
                    if (cs_rise) begin
                        state <= DONE;
                    end else if (sclk_rise) begin
                        rx_sr <= {rx_sr[30:0], mosi_s[1]};
                        if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
                    end else if (sclk_fall) begin
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            tx_sr[p] <= {tx_sr[p][30:0], 1'b0};
                            miso[p]  <= tx_sr[p][30];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    miso  <= '0;
                    if (bit_cnt == 6'd32) begin
                        res_q1      <= result;
                        res_q2      <= res_q1;
                        frame_count <= frame_count + 16'd1;
                        if (op == 2'b01)
                            conv_count <= '0;
                        else if (op == 2'b00 && 32'(ch) == NUM_CHANNELS - 1)
                            conv_count <= conv_count + 16'd1;
                        if (op == 2'b10 && 32'(addr) < REG_DEPTH)
                            regs[addr[AW-1:0]] <= wdata;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rhs_headstage_emulator_array.sv
// Directed + random SPI frames against a queue-based model of the emulator's command semantics.
module tb_rhs_headstage_emulator_array;
    localparam int          NP  = 16;
    localparam int          NC  = 16;
    localparam int          SB  = 2048;
    localparam int          SS  = 16;
    localparam int          RD  = 32;
    localparam logic [15:0] CID = 16'h0020;
    localparam int          HP  = 6;
    localparam logic [31:0] DUMMY = 32'hC0FE_0000;

    typedef logic [NP-1:0][31:0] resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        test_mode = 1'b0;
    logic [15:0] frame_count;
    logic        frame_error;

    rhs_headstage_emulator_array_if #(.NUM_PORTS(NP)) spi();

    rhs_headstage_emulator_array #(
        .NUM_PORTS(NP), .NUM_CHANNELS(NC), .SEED_BASE(16'(SB)), .SEED_STRIDE(16'(SS)),
        .REG_DEPTH(RD), .CHIP_ID(CID)
    ) dut (
        .clk(clk), .reset(reset), .spi(spi), .test_mode(test_mode),
        .frame_count(frame_count), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;

    always @(posedge clk) if (frame_error === 1'b1) err_cnt++;

    int          m_conv;
    int          m_frames;
    logic [15:0] m_regs [RD];
    resp_t       exp_q [$];
    resp_t       rx;

    task automatic model_reset();
        m_conv = 0;
        m_frames = 0;
        for (int i = 0; i < RD; i++) m_regs[i] = '0;
        exp_q = {};
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic model_cmd(input logic [31:0] cmd, input logic tm, output resp_t r);
        int ch, addr, v;
        ch   = int'(cmd[21:16]);
        addr = int'(cmd[23:16]);
        r = '0;
        case (cmd[31:30])
            2'b00: begin
                if (ch < NC)
                    for (int p = 0; p < NP; p++) begin
                        v = tm ? (32'h5555 ^ p) : (SB + p * SS + ch + m_conv);
                        r[p] = 32'((ch << 16) | (v & 32'hFFFF));
                    end
                if (ch == NC - 1) m_conv = (m_conv + 1) % 65536;
            end
            2'b01: m_conv = 0;
            2'b10: begin
                for (int p = 0; p < NP; p++) r[p] = {16'hFFFF, cmd[15:0]};
                if (addr < RD) m_regs[addr] = cmd[15:0];
            end
            default: begin
                v = (addr < RD) ? int'(m_regs[addr]) : (addr == 255 ? int'(CID) : 0);
                for (int p = 0; p < NP; p++) r[p] = 32'(v);
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input resp_t got, input resp_t exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sclk_bit(input logic b, input int idx);
        spi.MOSI = b;
        repeat (HP) @(negedge clk);
        spi.SCLK = 1'b1;
        if (idx < 32)
            for (int p = 0; p < NP; p++) rx[p][31-idx] = spi.MISO[p];
        repeat (HP) @(negedge clk);
        spi.SCLK = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] cmd, input int nbits);
        rx = '0;
        spi.CS = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nbits; i++) sclk_bit((i < 32) ? cmd[31-i] : 1'b0, i);
        repeat (HP) @(negedge clk);
        spi.CS = 1'b1;
        repeat (2 * HP) @(negedge clk);
    endtask

    task automatic check_frame(input logic [31:0] cmd);
        resp_t e, r;
        xfer(cmd, 32);
        e = exp_q.pop_front();
        model_cmd(cmd, test_mode, r);
        exp_q.push_back(r);
        m_frames++;
        chk_resp("resp", rx, e);
        chk("frame_count", 32'(frame_count), 32'(16'(m_frames)));
        chk("miso_idle", 32'(spi.MISO), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int e0;
        logic [15:0] fc0;
        logic [31:0] cmd, sweep_p0;

        spi.MOSI = 1'b0;
        spi.CS   = 1'b1;
        spi.SCLK = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_frame_count", 32'(frame_count), 32'h0);
        chk("rst_frame_error", 32'(frame_error), 32'h0);
        chk("rst_miso", 32'(spi.MISO), 32'h0);

        // CONVERT ch3 three times: answer arrives in the third frame
        for (int k = 0; k < 3; k++) check_frame(32'h0003_0000);
        chk("ch3_p0", rx[0], 32'h0003_0803);
        chk("ch3_p15", rx[15], 32'h0003_08F3);

        // two full sweeps; the last channel of the first sweep bumps conv_count
        do_reset();
        sweep_p0 = '0;
        for (int k = 0; k < 34; k++) begin
            check_frame(k < 32 ? {10'b0, 6'(k % 16), 16'h0} : DUMMY);
            if (k == 18) sweep_p0 = rx[0];
        end
        chk("sweep_ch0_p0", sweep_p0, 32'h0000_0801);
        chk("sweep_frames", 32'(frame_count), 32'd34);

        // register write / read-back / chip id
        check_frame(32'h8005_BEEF);
        check_frame(32'hC005_0000);
        check_frame(32'hC0FF_0000);
        chk_resp("wr_echo", rx, {NP{32'hFFFF_BEEF}});
        check_frame(DUMMY);
        chk_resp("rd_reg5", rx, {NP{32'h0000_BEEF}});
        check_frame(DUMMY);
        chk_resp("rd_chip_id", rx, {NP{32'h0000_0020}});

        // short (31) and long (33) frames between valid converts
        check_frame(32'h0002_0000);
        e0 = err_cnt;
        fc0 = frame_count;
        xfer(32'h0005_0000, 31);
        chk("short_err_pulse", 32'(err_cnt - e0), 32'd1);
        chk("short_frame_count", 32'(frame_count), 32'(fc0));
        check_frame(32'h0007_0000);
        e0 = err_cnt;
        xfer(32'h0009_0000, 33);
        chk("long_err_pulse", 32'(err_cnt - e0), 32'd1);
        chk("long_frame_count", 32'(frame_count), 32'(fc0 + 16'd1));
        check_frame(DUMMY);
        check_frame(DUMMY);

        // fixed pattern mode and out-of-range channel
        test_mode = 1'b1;
        check_frame(32'h0000_0000);
        check_frame(DUMMY);
        check_frame(DUMMY);
        chk("tm1_p0", rx[0], 32'h0000_5555);
        chk("tm1_p3", rx[3], 32'h0000_5556);
        check_frame(32'h0028_0000);
        check_frame(DUMMY);
        check_frame(DUMMY);
        chk_resp("ch40_zero", rx, '0);

        // random command mix
        for (int k = 0; k < 30; k++) begin
            cmd = $urandom;
            case ($urandom_range(0, 5))
                0, 1: begin cmd[31:30] = 2'b00; cmd[21:16] = ($urandom_range(0, 2) == 0) ? 6'd15 : 6'($urandom_range(0, 20)); end
                2:    cmd[31:30] = 2'b01;
                3:    begin cmd[31:30] = 2'b10; cmd[23:16] = 8'($urandom_range(0, 40)); end
                default: begin
                    cmd[31:30] = 2'b11;
                    cmd[23:16] = ($urandom_range(0, 4) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
                end
            endcase
            test_mode = 1'($urandom_range(0, 1));
            check_frame(cmd);
        end
        test_mode = 1'b0;

        // reset in the middle of a frame at bit 17
        cmd = 32'h8003_1234;
        spi.CS = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 17; i++) sclk_bit(cmd[31-i], i);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_miso", 32'(spi.MISO), 32'h0);
        reset = 1'b0;
        model_reset();
        e0 = err_cnt;
        for (int i = 17; i < 32; i++) sclk_bit(cmd[31-i], i);
        repeat (HP) @(negedge clk);
        spi.CS = 1'b1;
        repeat (2 * HP) @(negedge clk);
        chk("midrst_no_err", 32'(err_cnt - e0), 32'd0);
        chk("midrst_frames", 32'(frame_count), 32'h0);
        for (int k = 0; k < 3; k++) check_frame(32'h0003_0000);
        chk("midrst_ch3_p0", rx[0], 32'h0003_0803);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
